// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for RV32I R-type ALU instructions.
// Drives the data_path control inputs; any unsupported encoding parks it in HALT.
module control_sequencer #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned RETIRE_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    output logic [PC_WIDTH-1:0]     instr_addr,
    output logic                    instr_req,
    input  logic [31:0]             instr_data,
    input  logic                    zero_flag,
    output logic [4:0]              read_reg_num1,
    output logic [4:0]              read_reg_num2,
    output logic [4:0]              write_reg,
    output logic [3:0]              alu_control,
    output logic                    regwrite,
    output logic                    last_zero,
    output logic [RETIRE_WIDTH-1:0] retired,
    output logic                    halted
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t                  state, next_state;
    logic [PC_WIDTH-1:0]     pc;
    logic [31:0]             instr_reg;
    logic [4:0]              fetched_dec;
    logic [4:0]              held_dec;

    // Returns {legal, alu_code}; illegal encodings yield code 0000.
    function automatic logic [4:0] decode(input logic [31:0] word);
        logic [4:0] result;
        result = '0;
        if (word[6:0] == 7'b0110011) begin
            case ({word[31:25], word[14:12]})
                {7'b0000000, 3'b000}: result = {1'b1, 4'b0010};
                {7'b0100000, 3'b000}: result = {1'b1, 4'b0100};
                {7'b0000000, 3'b001}: result = {1'b1, 4'b0011};
                {7'b0000000, 3'b010}: result = {1'b1, 4'b1000};
                {7'b0000000, 3'b011}: result = {1'b1, 4'b1001};
                {7'b0000000, 3'b100}: result = {1'b1, 4'b0101};
                {7'b0000000, 3'b101}: result = {1'b1, 4'b0110};
                {7'b0100000, 3'b101}: result = {1'b1, 4'b0111};
                {7'b0000000, 3'b110}: result = {1'b1, 4'b0001};
                {7'b0000000, 3'b111}: result = {1'b1, 4'b0000};
                default:              result = '0;
            endcase
        end
        return result;
    endfunction

    assign fetched_dec = decode(instr_data);
    assign held_dec    = decode(instr_reg);

    // Control fields come straight from the latched word, so they hold through EXEC and WB.
    assign read_reg_num1 = instr_reg[19:15];
    assign read_reg_num2 = instr_reg[24:20];
    assign write_reg     = instr_reg[11:7];
    assign alu_control   = held_dec[3:0];
    assign instr_addr    = pc;
    assign halted        = (state == HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= PC_WIDTH'(RESET_PC);
            instr_reg <= '0;
            last_zero <= 1'b0;
            retired   <= '0;
        end else if (enable) begin
            state <= next_state;
            case (state)
                DECODE: instr_reg <= instr_data;
                WB: begin
                    last_zero <= zero_flag;
                    retired   <= retired + RETIRE_WIDTH'(1);
                    pc        <= pc + PC_WIDTH'(4);
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by reset/enable so a frozen or resetting WB never writes.
    always_comb begin
        next_state = state;
        instr_req  = 1'b0;
        regwrite   = 1'b0;
        case (state)
            FETCH: begin
                instr_req  = enable && !reset;
                next_state = DECODE;
            end
            DECODE:  next_state = fetched_dec[4] ? EXEC : HALT;
            EXEC:    next_state = WB;
            WB: begin
                regwrite   = enable && !reset && (instr_reg[11:7] != 5'd0);
                next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: instruction memory model plus hand-computed checks.
module tb_control_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        zero_flag;
    logic [4:0]  read_reg_num1;
    logic [4:0]  read_reg_num2;
    logic [4:0]  write_reg;
    logic [3:0]  alu_control;
    logic        regwrite;
    logic        last_zero;
    logic [15:0] retired;
    logic        halted;

    logic [31:0] mem [0:7];
    int          total;
    int          bad;
    int          wr_count;
    int          wr_base;

    control_sequencer #(
        .PC_WIDTH    (32),
        .RESET_PC    (0),
        .RETIRE_WIDTH(16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .instr_addr   (instr_addr),
        .instr_req    (instr_req),
        .instr_data   (instr_data),
        .zero_flag    (zero_flag),
        .read_reg_num1(read_reg_num1),
        .read_reg_num2(read_reg_num2),
        .write_reg    (write_reg),
        .alu_control  (alu_control),
        .regwrite     (regwrite),
        .last_zero    (last_zero),
        .retired      (retired),
        .halted       (halted)
    );

    assign instr_data = mem[instr_addr[4:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (regwrite) wr_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        wr_count  = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        zero_flag = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h0020_81B3;  // ADD x3,x1,x2
        mem[1] = 32'h4073_02B3;  // SUB x5,x6,x7
        mem[2] = 32'h0000_0013;  // ADDI -> illegal
        step();
        step();
        check("rst_addr", instr_addr, 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_req", 32'(instr_req), 32'd0);
        check("rst_alu", 32'(alu_control), 32'd0);
        check("rst_lastzero", 32'(last_zero), 32'd0);
        reset = 1'b0;
        #1;
        // ADD x3,x1,x2
        check("add_req", 32'(instr_req), 32'd1);
        check("add_fetch_addr", instr_addr, 32'd0);
        step();
        check("add_dec_req", 32'(instr_req), 32'd0);
        step();
        check("add_rs1", 32'(read_reg_num1), 32'd1);
        check("add_rs2", 32'(read_reg_num2), 32'd2);
        check("add_rd", 32'(write_reg), 32'd3);
        check("add_alu", 32'(alu_control), 32'b0010);
        check("add_exec_wr", 32'(regwrite), 32'd0);
        step();
        check("add_wb_wr", 32'(regwrite), 32'd1);
        step();
        check("add_retired", 32'(retired), 32'd1);
        check("add_next_addr", instr_addr, 32'd4);
        check("add_lastzero", 32'(last_zero), 32'd0);
        check("add_after_wr", 32'(regwrite), 32'd0);
        // SUB x5,x6,x7 with zero_flag set during WB
        step();
        step();
        check("sub_alu", 32'(alu_control), 32'b0100);
        check("sub_rd", 32'(write_reg), 32'd5);
        zero_flag = 1'b1;
        step();
        check("sub_wb_wr", 32'(regwrite), 32'd1);
        step();
        zero_flag = 1'b0;
        check("sub_lastzero", 32'(last_zero), 32'd1);
        check("sub_retired", 32'(retired), 32'd2);
        check("sub_next_addr", instr_addr, 32'd8);
        // ADDI at pc=8 halts after DECODE
        step();
        check("ill_not_halted_yet", 32'(halted), 32'd0);
        step();
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_pc", instr_addr, 32'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_wr", 32'(regwrite), 32'd0);
            check("halt_req", 32'(instr_req), 32'd0);
            check("halt_sticky", 32'(halted), 32'd1);
            check("halt_pc", instr_addr, 32'd8);
        end
        check("halt_retired", 32'(retired), 32'd2);

        // Second program: rd==0, enable freeze in EXEC and in WB
        mem[0] = 32'h0020_8033;  // ADD x0,x1,x2
        mem[1] = 32'h0020_81B3;  // ADD x3,x1,x2
        mem[2] = 32'h40B5_54B3;  // SRA x9,x10,x11
        mem[3] = 32'h0020_81B3;  // ADD x3,x1,x2
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check("r2_halted", 32'(halted), 32'd0);
        check("r2_retired", 32'(retired), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("x0_no_wr", 32'(regwrite), 32'd0);
            step();
        end
        check("x0_retired", 32'(retired), 32'd1);
        check("x0_pc", instr_addr, 32'd4);
        step();
        step();
        check("frz_rd", 32'(write_reg), 32'd3);
        wr_base = wr_count;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_wr", 32'(regwrite), 32'd0);
            check("frz_rd_hold", 32'(write_reg), 32'd3);
            check("frz_alu_hold", 32'(alu_control), 32'b0010);
            check("frz_pc", instr_addr, 32'd4);
        end
        enable = 1'b1;
        #1;
        check("frz_exec_wr", 32'(regwrite), 32'd0);
        step();
        check("frz_wb_wr", 32'(regwrite), 32'd1);
        step();
        check("frz_pulses", 32'(wr_count - wr_base), 32'd1);
        check("frz_retired", 32'(retired), 32'd2);
        check("frz_pc_next", instr_addr, 32'd8);
        // SRA with enable dropped in WB
        step();
        step();
        check("sra_alu", 32'(alu_control), 32'b0111);
        check("sra_rs1", 32'(read_reg_num1), 32'd10);
        check("sra_rs2", 32'(read_reg_num2), 32'd11);
        check("sra_rd", 32'(write_reg), 32'd9);
        wr_base = wr_count;
        step();
        check("sra_wb_wr", 32'(regwrite), 32'd1);
        enable = 1'b0;
        #1;
        check("wbfrz_wr", 32'(regwrite), 32'd0);
        step();
        check("wbfrz_hold_wr", 32'(regwrite), 32'd0);
        check("wbfrz_retired", 32'(retired), 32'd2);
        enable = 1'b1;
        #1;
        check("wbfrz_resume_wr", 32'(regwrite), 32'd1);
        step();
        check("wbfrz_pulses", 32'(wr_count - wr_base), 32'd1);
        check("wbfrz_retired_after", 32'(retired), 32'd3);
        check("wbfrz_pc", instr_addr, 32'd12);
        // Reset asserted during WB
        step();
        step();
        step();
        check("rstwb_pre_wr", 32'(regwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rstwb_wr", 32'(regwrite), 32'd0);
        step();
        check("rstwb_addr", instr_addr, 32'd0);
        check("rstwb_retired", 32'(retired), 32'd0);
        check("rstwb_wr_after", 32'(regwrite), 32'd0);
        reset = 1'b0;
        #1;
        check("rstwb_refetch", 32'(instr_req), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
